// File: rtl/ddr3_pkg.sv
// ddr3_pkg: constants and types shared by the DDR3 frame-buffer masters.
package ddr3_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int BEAT_BYTES = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } rd_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_rd_credit.sv
// ddr3_rd_credit: tracks beats requested but not yet received and decides
// whether a burst of this_len beats still fits in the read FIFO.
module ddr3_rd_credit #(
    parameter int CW         = 11,
    parameter int FIFO_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ar_fire,
    input  logic          r_fire,
    input  logic [CW-1:0] this_len,
    input  logic [8:0]    fifo_level,
    output logic          credit_ok
);

    localparam int SW = CW + 2;

    logic [CW-1:0] outstanding;

    assign credit_ok = (SW'(fifo_level) + SW'(outstanding) + SW'(this_len)) <= SW'(FIFO_DEPTH);

    // A burst grant and a returned beat in the same cycle both apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding <= '0;
        else
            outstanding <= outstanding + (ar_fire ? this_len : '0) - CW'(r_fire);
    end

endmodule

// File: rtl/ddr3_rd_master.sv
// ddr3_rd_master: fetches one frame from DDR3 over AXI4 read bursts and pushes
// every beat into the read-side FIFO, only requesting bursts the FIFO can absorb.
module ddr3_rd_master
    import ddr3_pkg::*;
#(
    parameter int ADDR_WIDTH  = 28,
    parameter int DATA_WIDTH  = 256,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BEATS = 1024,
    parameter int FIFO_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic [8:0]            fifo_level
);

    localparam int CW = $clog2(max_int(FRAME_BEATS, FIFO_DEPTH)) + 1;

    rd_state_e     state, state_nxt;
    logic [CW-1:0] ar_left, rx_left, this_len;
    logic          credit_ok, ar_hold, ar_fire, r_fire, last_beat, start;
    logic          unused_rlast;

    assign unused_rlast = m_rlast;
    assign this_len     = (ar_left < CW'(BURST_LEN)) ? ar_left : CW'(BURST_LEN);
    assign busy         = state != ST_IDLE;
    assign m_rready     = busy;
    assign r_fire       = m_rvalid && m_rready;
    assign start        = frame_start && state == ST_IDLE;
    // Once raised, arvalid holds until accepted even if the credit view shifts.
    assign m_arvalid    = state == ST_RUN && ar_left != '0 && (credit_ok || ar_hold);
    assign ar_fire      = m_arvalid && m_arready;
    assign m_arlen      = m_arvalid ? 8'(this_len - CW'(1)) : 8'h00;
    assign fifo_wr_en   = r_fire;
    assign fifo_wr_data = r_fire ? m_rdata : '0;
    assign last_beat    = r_fire && rx_left == CW'(1);

    ddr3_rd_credit #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .ar_fire    (ar_fire),
        .r_fire     (r_fire),
        .this_len   (this_len),
        .fifo_level (fifo_level),
        .credit_ok  (credit_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = frame_start ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nxt = (ar_fire && ar_left == this_len) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt = last_beat ? ST_IDLE : ST_DRAIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_araddr   <= '0;
            ar_left    <= '0;
            rx_left    <= '0;
            rd_err     <= 1'b0;
            frame_done <= 1'b0;
            ar_hold    <= 1'b0;
        end else begin
            frame_done <= last_beat;
            ar_hold    <= m_arvalid && !m_arready;
            if (start) begin
                m_araddr <= frame_base;
                ar_left  <= CW'(FRAME_BEATS);
                rx_left  <= CW'(FRAME_BEATS);
                rd_err   <= 1'b0;
            end else begin
                if (ar_fire) begin
                    m_araddr <= m_araddr + ADDR_WIDTH'(this_len * BEAT_BYTES);
                    ar_left  <= ar_left - this_len;
                end
                if (r_fire) begin
                    rx_left <= rx_left - CW'(1);
                    if (m_rresp != AXI_RESP_OKAY)
                        rd_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rd_master.sv
// tb_ddr3_rd_master: scoreboard bench with an AXI read responder; two instances
// (64-beat and 40-beat frames) share the bus stimulus, selected by sel.
module tb_ddr3_rd_master;

    localparam int AW = 28;
    localparam int DW = 256;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0, fs = 1'b0;
    logic [AW-1:0] frame_base = '0;
    logic          m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic [8:0]    fifo_level = '0;
    logic          ar_en = 1'b1, rv_en = 1'b1;
    int            err_beat = -1;

    logic          a_busy, a_done, a_err, a_arvalid, a_rready, a_wr_en;
    logic [AW-1:0] a_araddr;
    logic [7:0]    a_arlen;
    logic [DW-1:0] a_wr_data;
    logic          b_busy, b_done, b_err, b_arvalid, b_rready, b_wr_en;
    logic [AW-1:0] b_araddr;
    logic [7:0]    b_arlen;
    logic [DW-1:0] b_wr_data;

    logic          o_busy, o_done, o_err, o_arvalid, o_rready, o_wr_en;
    logic [AW-1:0] o_araddr;
    logic [7:0]    o_arlen;
    logic [DW-1:0] o_wr_data;

    assign o_busy    = sel ? b_busy    : a_busy;
    assign o_done    = sel ? b_done    : a_done;
    assign o_err     = sel ? b_err     : a_err;
    assign o_arvalid = sel ? b_arvalid : a_arvalid;
    assign o_rready  = sel ? b_rready  : a_rready;
    assign o_wr_en   = sel ? b_wr_en   : a_wr_en;
    assign o_araddr  = sel ? b_araddr  : a_araddr;
    assign o_arlen   = sel ? b_arlen   : a_arlen;
    assign o_wr_data = sel ? b_wr_data : a_wr_data;

    ddr3_rd_master #(.FRAME_BEATS(64)) u_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs && !sel), .frame_base(frame_base),
        .busy(a_busy), .frame_done(a_done), .rd_err(a_err),
        .m_araddr(a_araddr), .m_arlen(a_arlen), .m_arvalid(a_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(a_rready), .fifo_wr_en(a_wr_en), .fifo_wr_data(a_wr_data),
        .fifo_level(fifo_level)
    );

    ddr3_rd_master #(.FRAME_BEATS(40)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs && sel), .frame_base(frame_base),
        .busy(b_busy), .frame_done(b_done), .rd_err(b_err),
        .m_araddr(b_araddr), .m_arlen(b_arlen), .m_arvalid(b_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(b_rready), .fifo_wr_en(b_wr_en), .fifo_wr_data(b_wr_data),
        .fifo_level(fifo_level)
    );

    int total = 0, bad = 0;
    int dones = 0, pushes = 0, ar_cnt = 0, arv_cycles = 0, mon_out = 0;
    ar_t           exp_ar[$];
    logic [DW-1:0] exp_d[$];
    beat_t         bq[$];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8{{4'h0, a}}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected bursts and beat data are derived from the base address alone.
    task automatic start(input logic [AW-1:0] base);
        int beats, left, l;
        logic [AW-1:0] a;
        ar_t e;
        beats = sel ? 40 : 64;
        left  = beats;
        a     = base;
        @(posedge clk); #1;
        frame_base = base;
        fs = 1'b1;
        while (left > 0) begin
            l = (left < 16) ? left : 16;
            e.addr = a;
            e.len  = 8'(l - 1);
            exp_ar.push_back(e);
            a += AW'(l * 32);
            left -= l;
        end
        for (int i = 0; i < beats; i++) exp_d.push_back(pat(base + AW'(i * 32)));
        @(posedge clk); #1;
        fs = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0, n;
        d0 = dones;
        n  = 0;
        while (dones == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_seen"}, DW'(dones != d0), DW'(1));
        repeat (2) @(posedge clk);
        #1;
        check({name, "_busy_low"}, DW'(o_busy), DW'(0));
        check({name, "_data_left"}, DW'(exp_d.size()), DW'(0));
        check({name, "_ar_left"}, DW'(exp_ar.size()), DW'(0));
    endtask

    // Monitor: pops expectations whenever the DUT shows a handshake or push.
    logic          stall_q = 1'b0;
    logic [AW-1:0] stall_addr;
    logic [7:0]    stall_len;
    always @(negedge clk) begin
        ar_t e;
        if (!rst_n) begin
            stall_q = 1'b0;
            mon_out = 0;
        end else begin
            if (stall_q) begin
                check("ar_hold_valid", DW'(o_arvalid), DW'(1));
                check("ar_hold_addr", DW'(o_araddr), DW'(stall_addr));
                check("ar_hold_len", DW'(o_arlen), DW'(stall_len));
            end
            stall_q    = o_arvalid && !m_arready;
            stall_addr = o_araddr;
            stall_len  = o_arlen;
            if (o_arvalid) arv_cycles++;
            if (o_arvalid && m_arready) begin
                ar_cnt++;
                check("credit", DW'(mon_out + int'(o_arlen) + 1 + int'(fifo_level) <= 256), DW'(1));
                mon_out += int'(o_arlen) + 1;
                if (exp_ar.size() == 0)
                    check("ar_extra", DW'(exp_ar.size()), DW'(1));
                else begin
                    e = exp_ar.pop_front();
                    check("ar_addr", DW'(o_araddr), DW'(e.addr));
                    check("ar_len", DW'(o_arlen), DW'(e.len));
                end
            end
            if (o_wr_en) begin
                pushes++;
                mon_out--;
                if (exp_d.size() == 0)
                    check("data_extra", DW'(exp_d.size()), DW'(1));
                else
                    check("fifo_data", o_wr_data, exp_d.pop_front());
            end
            if (o_done) begin
                dones++;
                check("done_busy", DW'(o_busy), DW'(0));
            end
        end
    end

    // AXI read responder: serves beats in order, pattern data keyed by address.
    initial begin
        logic af, rf, fss;
        logic [AW-1:0] ca;
        logic [7:0] cl;
        int served;
        beat_t b;
        served = 0;
        forever begin
            @(negedge clk);
            af  = o_arvalid && m_arready;
            rf  = m_rvalid && o_rready;
            fss = fs;
            ca  = o_araddr;
            cl  = o_arlen;
            @(posedge clk); #1;
            if (!rst_n)
                bq.delete();
            else begin
                if (fss) served = 0;
                if (rf && bq.size() > 0) begin
                    void'(bq.pop_front());
                    served++;
                end
                if (af)
                    for (int i = 0; i <= int'(cl); i++) begin
                        b.addr = ca + AW'(i * 32);
                        b.last = (i == int'(cl));
                        bq.push_back(b);
                    end
            end
            m_arready = ar_en;
            m_rvalid  = rv_en && bq.size() > 0;
            m_rdata   = (bq.size() > 0) ? pat(bq[0].addr) : '0;
            m_rlast   = (bq.size() > 0) ? bq[0].last : 1'b0;
            m_rresp   = (bq.size() > 0 && served == err_beat) ? 2'b10 : 2'b00;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        int p0, a0, v0, n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", DW'(o_busy), DW'(0));
        check("rst_arvalid", DW'(o_arvalid), DW'(0));
        check("rst_rready", DW'(o_rready), DW'(0));
        check("rst_araddr", DW'(o_araddr), DW'(0));
        check("rst_arlen", DW'(o_arlen), DW'(0));
        check("rst_wr_en", DW'(o_wr_en), DW'(0));
        check("rst_done", DW'(o_done), DW'(0));
        check("rst_err", DW'(o_err), DW'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 64 beats, four full bursts
        p0 = pushes; a0 = ar_cnt; v0 = dones;
        start(28'h010_0000);
        wait_done("t1");
        check("t1_pushes", DW'(pushes - p0), DW'(64));
        check("t1_ars", DW'(ar_cnt - a0), DW'(4));
        check("t1_done_once", DW'(dones - v0), DW'(1));

        // 40 beats: 16,16,8
        sel = 1'b1;
        p0 = pushes; a0 = ar_cnt;
        start(28'h020_0000);
        wait_done("t2");
        check("t2_pushes", DW'(pushes - p0), DW'(40));
        check("t2_ars", DW'(ar_cnt - a0), DW'(3));
        sel = 1'b0;
        repeat (2) @(posedge clk);

        // FIFO nearly full holds off requests
        fifo_level = 9'd245;
        a0 = ar_cnt; v0 = arv_cycles;
        start(28'h030_0000);
        repeat (10) @(posedge clk);
        #1;
        check("t3_no_arvalid", DW'(arv_cycles - v0), DW'(0));
        fifo_level = 9'd240;
        n = 0;
        while (ar_cnt == a0 && n < 4) begin
            @(posedge clk);
            n++;
        end
        check("t3_ar_after_drop", DW'(ar_cnt - a0), DW'(1));
        wait_done("t3");
        check("t3_ars", DW'(ar_cnt - a0), DW'(4));
        fifo_level = 9'd0;

        // arready held low
        ar_en = 1'b0;
        a0 = ar_cnt;
        start(28'h040_0000);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_ar_fire", DW'(ar_cnt - a0), DW'(0));
        check("t4_arvalid_waiting", DW'(o_arvalid), DW'(1));
        check("t4_addr_waiting", DW'(o_araddr), DW'(28'h040_0000));
        ar_en = 1'b1;
        wait_done("t4");
        check("t4_ars", DW'(ar_cnt - a0), DW'(4));

        // error response on beat 5
        err_beat = 5;
        p0 = pushes;
        start(28'h050_0000);
        check("t5_err_clear_at_start", DW'(o_err), DW'(0));
        wait_done("t5");
        check("t5_err_sticky", DW'(o_err), DW'(1));
        check("t5_pushes", DW'(pushes - p0), DW'(64));
        err_beat = -1;
        start(28'h060_0000);
        check("t5_err_cleared", DW'(o_err), DW'(0));
        wait_done("t5b");
        check("t5b_err", DW'(o_err), DW'(0));

        // reset mid-frame after two bursts
        a0 = ar_cnt;
        start(28'h070_0000);
        n = 0;
        while (ar_cnt - a0 < 2 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("t6_two_ars", DW'(ar_cnt - a0 >= 2), DW'(1));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_busy", DW'(a_busy), DW'(0));
        check("t6_arvalid", DW'(a_arvalid), DW'(0));
        check("t6_rready", DW'(a_rready), DW'(0));
        check("t6_wr_en", DW'(a_wr_en), DW'(0));
        check("t6_wr_data", a_wr_data, DW'(0));
        check("t6_araddr", DW'(a_araddr), DW'(0));
        check("t6_arlen", DW'(a_arlen), DW'(0));
        check("t6_done", DW'(a_done), DW'(0));
        check("t6_err", DW'(a_err), DW'(0));
        repeat (3) @(posedge clk);
        exp_ar.delete();
        exp_d.delete();
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        p0 = pushes; a0 = ar_cnt;
        start(28'h070_0000);
        wait_done("t6");
        check("t6_pushes", DW'(pushes - p0), DW'(64));
        check("t6_ars", DW'(ar_cnt - a0), DW'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
